// File: rtl/tpmem_row_feeder.sv
// Row feeder for the 16x16 transpose memory. It packs N samples into one row
// and writes rows to the memory, holding the write strobe low while a block drains.
module tpmem_row_feeder #(
  parameter int BW = 11,
  parameter int N  = 16
) (
  input  logic            i_clk,
  input  logic            i_Reset,
  input  logic [BW-1:0]   i_sample,
  input  logic            i_valid,
  output logic            o_ready,
  output logic [N*BW-1:0] o_data,
  output logic            o_enable,
  output logic [3:0]      o_row_idx,
  output logic            o_block_end,
  output logic            o_gap
);

  localparam logic [3:0] LAST = 4'(N - 1);

  typedef enum logic {FILL, GAP} state_t;

  state_t            state_reg;
  logic [3:0]        slot_reg;
  logic [3:0]        row_reg;
  logic [3:0]        gap_cnt_reg;
  logic              pending_reg;
  logic [N*BW-1:0]   hold_reg;
  logic [N*BW-1:0]   data_reg;
  logic              enable_reg;
  logic              block_end_reg;
  logic              gap_reg;
  logic [3:0]        row_idx_reg;

  logic              accept;
  logic              row_done;
  logic              gap_end;
  logic              emit_ok;
  logic              emit_pending;
  logic              emit_new;
  logic [N*BW-1:0]   completed_row;
  logic [N*BW-1:0]   emit_row;

  assign accept       = i_valid & ~pending_reg;
  assign row_done     = accept && (slot_reg == LAST);
  // The last cycle of the drain window: an emission registered now lands just after it.
  assign gap_end      = (state_reg == GAP) && gap_reg && (gap_cnt_reg == LAST);
  assign emit_ok      = (state_reg == FILL) || gap_end;
  assign emit_pending = pending_reg & emit_ok;
  assign emit_new     = row_done & emit_ok;
  assign emit_row     = pending_reg ? hold_reg : completed_row;

  // Slot 0 occupies the MSB field; the final slot comes straight from the input so
  // a row can be emitted on the same edge that accepts its last sample.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_field
      if (gi == N - 1) begin : g_last
        assign completed_row[(N-gi)*BW-1 -: BW] = i_sample;
      end else begin : g_mid
        logic [BW-1:0] field_reg;
        always_ff @(posedge i_clk) begin
          if (i_Reset) begin
            field_reg <= '0;
          end else if (accept && (slot_reg == 4'(gi))) begin
            field_reg <= i_sample;
          end
        end
        assign completed_row[(N-gi)*BW-1 -: BW] = field_reg;
      end
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_Reset) begin
      state_reg     <= FILL;
      slot_reg      <= '0;
      row_reg       <= '0;
      gap_cnt_reg   <= '0;
      pending_reg   <= 1'b0;
      hold_reg      <= '0;
      data_reg      <= '0;
      enable_reg    <= 1'b0;
      block_end_reg <= 1'b0;
      gap_reg       <= 1'b0;
      row_idx_reg   <= '0;
    end else begin
      enable_reg    <= 1'b0;
      block_end_reg <= 1'b0;

      if (accept) begin
        slot_reg <= slot_reg + 4'd1;
      end

      if (emit_pending || emit_new) begin
        enable_reg    <= 1'b1;
        data_reg      <= emit_row;
        row_idx_reg   <= row_reg;
        block_end_reg <= (row_reg == LAST);
        row_reg       <= row_reg + 4'd1;
      end

      // Accept is blocked while pending, so a completion never meets a held row.
      if (emit_pending) begin
        pending_reg <= 1'b0;
      end else if (row_done && !emit_ok) begin
        pending_reg <= 1'b1;
        hold_reg    <= completed_row;
      end

      case (state_reg)
        FILL: begin
          if (emit_new && (row_reg == LAST)) begin
            state_reg   <= GAP;
            gap_cnt_reg <= '0;
          end
        end
        GAP: begin
          // First GAP cycle is the row-15 strobe itself; the window opens after it.
          if (!gap_reg) begin
            gap_reg     <= 1'b1;
            gap_cnt_reg <= '0;
          end else if (gap_cnt_reg != LAST) begin
            gap_cnt_reg <= gap_cnt_reg + 4'd1;
          end else begin
            gap_reg     <= 1'b0;
            gap_cnt_reg <= '0;
            state_reg   <= FILL;
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

  assign o_ready     = ~pending_reg;
  assign o_data      = data_reg;
  assign o_enable    = enable_reg;
  assign o_row_idx   = row_idx_reg;
  assign o_block_end = block_end_reg;
  assign o_gap       = gap_reg;

endmodule

// File: tb/tb_tpmem_row_feeder.sv
// Directed bench for tpmem_row_feeder: a scoreboard queue of expected rows is
// filled as samples are accepted and drained as row-write strobes appear.
module tb_tpmem_row_feeder;

  localparam int BW = 11;
  localparam int N  = 16;
  localparam int DW = N * BW;

  logic            i_clk = 1'b0;
  logic            i_Reset = 1'b1;
  logic [BW-1:0]   i_sample = '0;
  logic            i_valid = 1'b0;
  logic            o_ready;
  logic [DW-1:0]   o_data;
  logic            o_enable;
  logic [3:0]      o_row_idx;
  logic            o_block_end;
  logic            o_gap;

  always #5 i_clk = ~i_clk;

  tpmem_row_feeder #(.BW(BW), .N(N)) dut (
    .i_clk       (i_clk),
    .i_Reset     (i_Reset),
    .i_sample    (i_sample),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_data      (o_data),
    .o_enable    (o_enable),
    .o_row_idx   (o_row_idx),
    .o_block_end (o_block_end),
    .o_gap       (o_gap)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [3:0]    idx;
    logic          be;
    int            compl;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            passes = 0;
  int            cyc = 0;
  int            last15 = -1000;
  int            gap_run = 0;
  int            enables = 0;
  int            stalls = 0;
  logic          prev_gap = 1'b0;
  logic          prev_rst = 1'b1;
  logic [BW-1:0] fields[N];
  int            slot_m = 0;
  int            row_m = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observes the outputs produced by the previous rising edge.
  task automatic monitor();
    exp_t e;
    int   exp_cyc;
    if (prev_rst) begin
      last15   = -1000;
      prev_gap = 1'b0;
      gap_run  = 0;
    end else begin
      if (o_gap) begin
        if (!prev_gap) begin
          chk("gap_start", cyc, last15 + 1);
          gap_run = 0;
        end
        gap_run++;
      end else if (prev_gap) begin
        chk("gap_len", gap_run, 16);
      end
      prev_gap = o_gap;
      if (o_enable) begin
        enables++;
        chk("enable_in_gap", o_gap, 0);
        if (q.size() == 0) begin
          chk("unexpected_enable", o_enable, 0);
        end else begin
          e = q.pop_front();
          chk("row_data", o_data, e.data);
          chk("row_idx", o_row_idx, e.idx);
          chk("block_end", o_block_end, e.be);
          exp_cyc = e.compl + 1;
          if (e.idx == 0 && last15 + 17 > exp_cyc) exp_cyc = last15 + 17;
          chk("emit_cycle", cyc, exp_cyc);
          if (e.idx == 15) last15 = cyc;
        end
      end else begin
        chk("block_end_idle", o_block_end, 0);
      end
    end
  endtask

  task automatic step(input logic rst, input logic v, input logic [BW-1:0] s, output bit acc);
    exp_t e;
    @(negedge i_clk);
    cyc++;
    monitor();
    i_Reset  = rst;
    i_valid  = v;
    i_sample = s;
    acc      = !rst && v && (o_ready === 1'b1);
    prev_rst = rst;
    if (rst) begin
      slot_m = 0;
      row_m  = 0;
      q.delete();
    end else if (acc) begin
      fields[slot_m] = s;
      slot_m++;
      if (slot_m == N) begin
        for (int k = 0; k < N; k++) e.data[(N-k)*BW-1 -: BW] = fields[k];
        e.idx   = 4'(row_m);
        e.be    = (row_m == N - 1);
        e.compl = cyc;
        q.push_back(e);
        row_m  = (row_m + 1) % N;
        slot_m = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, a);
  endtask

  task automatic send(input logic [BW-1:0] s);
    bit acc;
    int tries;
    tries = 0;
    do begin
      step(1'b0, 1'b1, s, acc);
      if (!acc) stalls++;
      tries++;
    end while (!acc && tries < 64);
    if (!acc) chk("send_accept", acc, 1);
  endtask

  task automatic reset_dut(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 11'h5a5, a);
    step(1'b0, 1'b0, '0, a);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      idle(1);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    idle(20);
  endtask

  initial begin
    int en0;
    bit a;

    // 1: reset held for two cycles with valid asserted
    reset_dut(2);
    chk("rst_enable", o_enable, 0);
    chk("rst_gap", o_gap, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_data", o_data, 0);
    chk("rst_row_idx", o_row_idx, 0);
    chk("rst_block_end", o_block_end, 0);

    // 2: single row of samples 1..16
    en0 = enables;
    for (int k = 1; k <= 16; k++) send(BW'(k));
    step(1'b0, 1'b0, '0, a);
    chk("t2_enable", o_enable, 1);
    chk("t2_idx", o_row_idx, 0);
    chk("t2_msb_field", o_data[DW-1 -: BW], 1);
    chk("t2_lsb_field", o_data[BW-1:0], 16);
    drain();
    chk("t2_enables", enables - en0, 1);

    // 3: full block streamed continuously, value = row*16+col
    reset_dut(1);
    en0 = enables;
    stalls = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) send(BW'(r * 16 + c));
    chk("t3_stalls", stalls, 0);

    // 4: keep streaming into the gap; row 0 of block 2 has to wait
    stalls = 0;
    for (int i = 0; i < 256; i++) send(BW'(1024 + i));
    chk("t4_stalls", stalls, 1);
    drain();
    chk("t34_enables", enables - en0, 32);

    // 5: bursty valid over two blocks
    reset_dut(1);
    en0 = enables;
    for (int i = 0; i < 512; i++) begin
      idle($urandom_range(0, 2));
      send(BW'($urandom_range(0, (1 << BW) - 1)));
    end
    drain();
    chk("t5_enables", enables - en0, 32);

    // 6: reset after a partial row, then a fresh row A..P
    reset_dut(1);
    en0 = enables;
    for (int k = 0; k < 7; k++) send(BW'(7'h70 + k));
    reset_dut(1);
    for (int k = 0; k < 16; k++) send(BW'(12'h100 + k));
    drain();
    chk("t6_enables", enables - en0, 1);
    chk("t6_ready", o_ready, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
